// File: rtl/lsu_mem_stage_if.sv
// Bundles the EX request, data-memory port and writeback signals of lsu_mem_stage.
// The slave modport is the load/store stage; the master modport is its surroundings.
interface lsu_mem_stage_if #(
  parameter int unsigned REG_ADDR_W = 4
) ();
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;

  // EX-stage request
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [DATA_W-1:0]     addr_i;
  logic [DATA_W-1:0]     wdata_i;
  logic                  we_i;
  logic                  size_i;
  logic                  sign_ext_i;
  logic [REG_ADDR_W-1:0] rd_i;

  // Data-memory port
  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic [DATA_W-1:0]     mem_addr_o;
  logic                  mem_we_o;
  logic [BE_W-1:0]       mem_be_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic                  mem_rvalid_i;
  logic [DATA_W-1:0]     mem_rdata_i;

  // Writeback and status
  logic                  wb_valid_o;
  logic                  wb_we_o;
  logic [REG_ADDR_W-1:0] wb_rd_o;
  logic [DATA_W-1:0]     wb_data_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, addr_i, wdata_i, we_i, size_i, sign_ext_i, rd_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, busy_o
  );

  modport master (
    output req_valid_i, addr_i, wdata_i, we_i, size_i, sign_ext_i, rd_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, busy_o
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one req/gnt/rvalid transaction per op, byte-lane steering and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword ops skip memory and report misalign_o.
module lsu_mem_stage #(
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  lsu_mem_stage_if.slave bus
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic           misalign_o
`endif
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BE_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                r_state;
  logic                  r_addr0;
  logic                  r_size;
  logic                  r_sign_ext;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;

  logic                  w_accept;
  logic [BE_W-1:0]       w_be;
  logic [DATA_W-1:0]     w_wdata;
  logic [DATA_W-1:0]     w_aligned_addr;
  logic [BYTE_W-1:0]     w_byte;
  logic [DATA_W-1:0]     w_load_data;

  assign w_accept       = bus.req_valid_i & bus.req_ready_o;
  assign w_aligned_addr = {bus.addr_i[DATA_W-1:1], 1'b0};

  // Byte enables and lane-replicated store data from the incoming request
  always_comb begin
    w_be    = 2'b11;
    w_wdata = bus.wdata_i;
    if (!bus.size_i) begin
      w_be    = bus.addr_i[0] ? 2'b10 : 2'b01;
      w_wdata = {bus.wdata_i[BYTE_W-1:0], bus.wdata_i[BYTE_W-1:0]};
    end
  end

  // Load formatting from the latched attributes; stores return zero
  always_comb begin
    w_byte      = r_addr0 ? bus.mem_rdata_i[DATA_W-1:BYTE_W] : bus.mem_rdata_i[BYTE_W-1:0];
    w_load_data = {{BYTE_W{r_sign_ext & w_byte[BYTE_W-1]}}, w_byte};
    if (r_size) begin
      w_load_data = bus.mem_rdata_i;
    end
    if (r_we) begin
      w_load_data = '0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = bus.size_i & bus.addr_i[0];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= S_IDLE;
      r_addr0         <= 1'b0;
      r_size          <= 1'b0;
      r_sign_ext      <= 1'b0;
      r_we            <= 1'b0;
      r_rd            <= '0;
      bus.req_ready_o <= 1'b1;
      bus.busy_o      <= 1'b0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_be_o    <= '0;
      bus.mem_wdata_o <= '0;
      bus.wb_valid_o  <= 1'b0;
      bus.wb_we_o     <= 1'b0;
      bus.wb_rd_o     <= '0;
      bus.wb_data_o   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_o      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr0         <= bus.addr_i[0];
            r_size          <= bus.size_i;
            r_sign_ext      <= bus.sign_ext_i;
            r_we            <= bus.we_i;
            r_rd            <= bus.rd_i;
            bus.req_ready_o <= 1'b0;
            bus.busy_o      <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            if (w_misalign) begin
              // Trap: complete immediately without touching memory
              r_state        <= S_RESP;
              bus.wb_valid_o <= 1'b1;
              bus.wb_we_o    <= 1'b0;
              bus.wb_rd_o    <= bus.rd_i;
              bus.wb_data_o  <= '0;
              misalign_o     <= 1'b1;
            end else begin
              r_state         <= S_REQ;
              bus.mem_req_o   <= 1'b1;
              bus.mem_addr_o  <= w_aligned_addr;
              bus.mem_we_o    <= bus.we_i;
              bus.mem_be_o    <= w_be;
              bus.mem_wdata_o <= w_wdata;
            end
`else
            r_state         <= S_REQ;
            bus.mem_req_o   <= 1'b1;
            bus.mem_addr_o  <= w_aligned_addr;
            bus.mem_we_o    <= bus.we_i;
            bus.mem_be_o    <= w_be;
            bus.mem_wdata_o <= w_wdata;
`endif
          end
        end

        S_REQ: begin
          // Any rvalid seen here, even alongside gnt, is not ours
          if (bus.mem_gnt_i) begin
            r_state       <= S_WAIT;
            bus.mem_req_o <= 1'b0;
          end
        end

        S_WAIT: begin
          if (bus.mem_rvalid_i) begin
            r_state        <= S_RESP;
            bus.wb_valid_o <= 1'b1;
            bus.wb_we_o    <= ~r_we;
            bus.wb_rd_o    <= r_rd;
            bus.wb_data_o  <= w_load_data;
          end
        end

        S_RESP: begin
          r_state         <= S_IDLE;
          bus.req_ready_o <= 1'b1;
          bus.busy_o      <= 1'b0;
          bus.wb_valid_o  <= 1'b0;
          bus.wb_we_o     <= 1'b0;
          bus.wb_rd_o     <= '0;
          bus.wb_data_o   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_o      <= 1'b0;
`endif
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store stage directly downstream of the 16-bit ALU.
- Takes the ALU result as the effective address, plus rs2 data and the access attributes, from the EX stage.
- Runs one request/grant/response transaction per instruction on the data-memory port.
- Returns byte-aligned, sign- or zero-extended load data, or a store acknowledge, to writeback.

Parameters:
- REG_ADDR_W, 4, width of the destination register index carried through to writeback.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  1  EX stage presents a memory op.
- req_ready_o  output  1  stage can accept; high only in IDLE.
- addr_i  input  16  effective byte address (ALU result).
- wdata_i  input  16  store data (rs2).
- we_i  input  1  1=store, 0=load.
- size_i  input  1  0=byte, 1=halfword.
- sign_ext_i  input  1  1=sign-extend byte load, 0=zero-extend.
- rd_i  input  REG_ADDR_W  load destination register.
- mem_req_o  output  1  memory request.
- mem_gnt_i  input  1  memory accepted the request.
- mem_addr_o  output  16  halfword-aligned address (bit0 forced 0).
- mem_we_o  output  1  write enable.
- mem_be_o  output  2  byte enables.
- mem_wdata_o  output  16  lane-positioned store data.
- mem_rvalid_i  input  1  response valid (loads and stores).
- mem_rdata_i  input  16  raw read halfword.
- wb_valid_o  output  1  one-cycle completion pulse.
- wb_we_o  output  1  1 = write wb_data_o to wb_rd_o (loads only).
- wb_rd_o  output  REG_ADDR_W  destination register.
- wb_data_o  output  16  extended load data; 0 for stores.
- busy_o  output  1  high whenever not in IDLE.

Behaviour:
- Reset (async, rst_ni=0): FSM to IDLE; all outputs 0 except req_ready_o=1; latched request fields cleared; any in-flight response dropped.
- FSM states:
  - IDLE -> REQ on req_valid_i & req_ready_o. Latch addr, wdata, we, size, sign_ext, rd.
  - REQ: mem_req_o=1, with mem_addr_o/we/be/wdata stable from the latched fields. Stays in REQ until mem_gnt_i=1, then -> WAIT.
  - WAIT: mem_req_o=0. On mem_rvalid_i=1, capture and format the data, then -> RESP.
  - RESP: wb_valid_o=1 for exactly one cycle, then -> IDLE.
- Minimum latency with gnt in the first REQ cycle and rvalid on the first WAIT cycle:
  - accept at cycle N, mem_req_o at N+1, rvalid at N+2, wb_valid_o at N+3.
- Back-to-back: a new request can be accepted the cycle after RESP (IDLE). Throughput is 1 op per 4 cycles at best.
- Byte lanes:
  - Byte, addr[0]=0: be=01.
  - Byte, addr[0]=1: be=10.
  - Byte store: mem_wdata_o={wdata[7:0],wdata[7:0]}.
  - Halfword: be=11, wdata straight.
- Load formatting:
  - Byte: select rdata[7:0] when addr[0]=0, rdata[15:8] when addr[0]=1. Extend bit 7 of the selected byte if sign_ext, else pad with zeros.
  - Halfword: rdata unchanged.
- Stores: wb_we_o=0, wb_data_o=0; wb_valid_o still pulses on completion.
- Ignored inputs:
  - mem_rvalid_i in IDLE/REQ/RESP.
  - mem_gnt_i outside REQ.
  - req_valid_i while not IDLE. The upstream holds the request until ready.
- Simultaneous gnt and rvalid in the same REQ cycle: rvalid is ignored. The memory must respond at least one cycle after gnt.
- Address wrap: 16'hFFFF byte access gives mem_addr_o=16'hFFFE, be=10. No wrap to the next halfword.
- Misaligned halfword (size=1, addr[0]=1) without the optional feature: address aligned down, be=11, access proceeds normally.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_o (1 bit).
  - A misaligned halfword access issues no memory request. FSM goes IDLE -> RESP directly.
  - RESP cycle: wb_valid_o=1, wb_we_o=0, wb_data_o=0, misalign_o=1.
  - misalign_o resets to 0 and is 0 in all other cycles.
- Undefined: port absent; misaligned accesses aligned down as in Behaviour.

Test Plan:
- Halfword store: addr=16'h0102, wdata=16'hBEEF, gnt immediate, rvalid next cycle -> mem_addr_o=16'h0102, be=11, mem_wdata_o=16'hBEEF, mem_we_o=1; wb_valid_o at N+3 with wb_we_o=0.
- Signed byte load: addr=16'h0011, rdata=16'h80FF, sign_ext=1, rd=5 -> be=10, wb_data_o=16'hFF80, wb_rd_o=5, wb_we_o=1. Same load with sign_ext=0 -> 16'h0080.
- Grant stall: hold mem_gnt_i=0 for 3 cycles -> mem_req_o and address stable all 4 REQ cycles; req_ready_o=0; busy_o=1 throughout.
- Spurious rvalid pulsed in REQ, then real rvalid=16'h1234 for a halfword load -> wb_data_o=16'h1234; only one wb_valid_o pulse.
- Async reset asserted in WAIT -> all outputs 0 immediately, req_ready_o=1. A later rvalid produces no wb_valid_o.
- LSU_MISALIGN_TRAP_EN: halfword load at addr=16'h0003 -> mem_req_o never asserts; misalign_o=1 with wb_valid_o=1 in the cycle after accept.
